// File: rtl/bist_engine.sv
// Built-in self-test wrapper around an external arithmetic CUT: forwards operands in normal mode,
// runs LFSR pattern sessions with CRC compaction in test mode. Optional golden compare: BIST_GOLDEN_CMP_EN.
module bist_engine #(
    parameter int                   DW        = 8,
    parameter int                   RW        = 16,
    parameter int                   CNT_W     = 8,
    parameter int                   SIG_W     = 8,
    parameter logic [SIG_W-1:0]     SIG_POLY  = 8'h07,
    parameter logic [2*DW-1:0]      LFSR_TAPS = 16'hB400,
    parameter logic [2*DW-1:0]      LFSR_SEED = 16'h0001,
`ifdef BIST_GOLDEN_CMP_EN
    parameter logic [SIG_W-1:0]     GOLDEN_SIG = '0,
`endif
    parameter int                   N_PAT     = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          test,
    output logic [RW-1:0] out,
    output logic          done,
`ifdef BIST_GOLDEN_CMP_EN
    output logic          fail,
`endif
    output logic          cut_start,
    output logic [DW-1:0] cut_a,
    output logic [DW-1:0] cut_b,
    input  logic          cut_busy,
    input  logic [RW-1:0] cut_y
);

    typedef enum logic [2:0] {
        N_ISSUE,
        N_WAIT,
        T_SEED,
        T_ISSUE,
        T_WAIT,
        T_DONE
    } state_t;

    state_t            state_reg;
    logic              pend_reg;
    logic              test_q_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [SIG_W-1:0]  sig_reg;
    logic [2*DW-1:0]   lfsr_reg;
    logic [15:0]       pat_reg;

    logic              tog;
    logic              op_complete;
    logic [CNT_W-1:0]  cnt_inc;
    logic [15:0]       pat_inc;
    logic              last_pat;
    logic [2*DW-1:0]   lfsr_next;
    logic [SIG_W-1:0]  sig_next;

    // Serial MSB-first CRC over the whole result word, unrolled into one cycle.
    function automatic logic [SIG_W-1:0] crc_update(input logic [SIG_W-1:0] s,
                                                    input logic [RW-1:0]    d);
        logic [SIG_W-1:0] c;
        logic             fb;
        c = s;
        for (int i = RW - 1; i >= 0; i--) begin
            fb = c[SIG_W-1] ^ d[i];
            c  = {c[SIG_W-2:0], 1'b0} ^ ({SIG_W{fb}} & SIG_POLY);
        end
        return c;
    endfunction

    assign tog       = test & ~test_q_reg;
    // The start-pulse cycle is skipped: busy is only valid from the following cycle.
    assign op_complete = ~cut_start & ~cut_busy;
    assign cnt_inc   = cnt_reg + CNT_W'(1);
    assign pat_inc   = pat_reg + 16'd1;
    assign last_pat  = (pat_inc == 16'(N_PAT));
    assign lfsr_next = {lfsr_reg[2*DW-2:0], ^(lfsr_reg & LFSR_TAPS)};
    assign sig_next  = crc_update(sig_reg, cut_y);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= N_ISSUE;
            pend_reg   <= 1'b0;
            test_q_reg <= 1'b0;
            cnt_reg    <= '0;
            sig_reg    <= '0;
            lfsr_reg   <= LFSR_SEED;
            pat_reg    <= '0;
            out        <= '0;
            done       <= 1'b0;
            cut_start  <= 1'b0;
            cut_a      <= '0;
            cut_b      <= '0;
`ifdef BIST_GOLDEN_CMP_EN
            fail       <= 1'b0;
`endif
        end else begin
            test_q_reg <= test;
            cut_start  <= 1'b0;
            // Pending toggles accumulate; consumption points reload with the same-cycle toggle.
            pend_reg   <= pend_reg | tog;
            case (state_reg)
                N_ISSUE: begin
                    if (pend_reg) begin
                        pend_reg  <= tog;
                        state_reg <= T_SEED;
                    end else begin
                        cut_start <= 1'b1;
                        cut_a     <= a;
                        cut_b     <= b;
                        state_reg <= N_WAIT;
                    end
                end
                N_WAIT: begin
                    if (op_complete) begin
                        out <= cut_y;
                        if (pend_reg) begin
                            pend_reg  <= tog;
                            state_reg <= T_SEED;
                        end else begin
                            state_reg <= N_ISSUE;
                        end
                    end
                end
                T_SEED: begin
                    pend_reg  <= tog;
                    cnt_reg   <= cnt_inc;
                    sig_reg   <= '0;
                    lfsr_reg  <= LFSR_SEED;
                    pat_reg   <= '0;
                    done      <= 1'b0;
                    out       <= {cnt_inc, {SIG_W{1'b0}}};
`ifdef BIST_GOLDEN_CMP_EN
                    fail      <= 1'b0;
`endif
                    state_reg <= T_ISSUE;
                end
                T_ISSUE: begin
                    if (pend_reg) begin
                        pend_reg  <= tog;
                        state_reg <= N_ISSUE;
                    end else begin
                        cut_start      <= 1'b1;
                        {cut_a, cut_b} <= lfsr_reg;
                        lfsr_reg       <= lfsr_next;
                        state_reg      <= T_WAIT;
                    end
                end
                T_WAIT: begin
                    if (op_complete) begin
                        sig_reg <= sig_next;
                        pat_reg <= pat_inc;
                        out     <= {cnt_reg, sig_next};
                        if (pend_reg) begin
                            pend_reg  <= tog;
                            state_reg <= N_ISSUE;
                        end else if (last_pat) begin
                            done      <= 1'b1;
`ifdef BIST_GOLDEN_CMP_EN
                            fail      <= (sig_next != GOLDEN_SIG);
`endif
                            state_reg <= T_DONE;
                        end else begin
                            state_reg <= T_ISSUE;
                        end
                    end
                end
                T_DONE: begin
                    if (pend_reg) begin
                        pend_reg  <= tog;
                        done      <= 1'b0;
                        state_reg <= N_ISSUE;
                    end
                end
                default: state_reg <= N_ISSUE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_engine.sv
// Directed bench for bist_engine: CUT model y = a^3 + isqrt(b) with 3-cycle busy,
// normal-mode results, test sessions, mid-op mode toggles and async reset.
module tb_bist_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  a = 8'd2;
    logic [7:0]  b = 8'd3;
    logic        test = 1'b0;
    logic [15:0] out;
    logic        done;
`ifdef BIST_GOLDEN_CMP_EN
    logic        fail;
`endif
    logic        cut_start;
    logic [7:0]  cut_a;
    logic [7:0]  cut_b;
    logic        cut_busy;
    logic [15:0] cut_y;

    int n_checks = 0;
    int n_pass   = 0;
    int b2b_cnt  = 0;
    int busy_start_cnt = 0;
    logic prev_start = 1'b0;
    logic [7:0] exp_sig;

    always #5 clk = ~clk;

    bist_engine dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .test      (test),
        .out       (out),
        .done      (done),
`ifdef BIST_GOLDEN_CMP_EN
        .fail      (fail),
`endif
        .cut_start (cut_start),
        .cut_a     (cut_a),
        .cut_b     (cut_b),
        .cut_busy  (cut_busy),
        .cut_y     (cut_y)
    );

    function automatic logic [15:0] cut_fn(input logic [7:0] x, input logic [7:0] z);
        int xi, zi, r, cube;
        xi = int'(x);
        zi = int'(z);
        cube = xi * xi * xi;
        r = 0;
        while ((r + 1) * (r + 1) <= zi) r++;
        return 16'(cube + r);
    endfunction

    // CUT model: busy high for 3 cycles after a start, result valid once busy drops.
    logic [7:0] m_a, m_b;
    int         m_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cut_busy <= 1'b0;
            cut_y    <= '0;
            m_a      <= '0;
            m_b      <= '0;
            m_cnt    <= 0;
        end else if (cut_start) begin
            m_a      <= cut_a;
            m_b      <= cut_b;
            cut_busy <= 1'b1;
            m_cnt    <= 3;
        end else if (cut_busy) begin
            if (m_cnt == 1) begin
                cut_busy <= 1'b0;
                cut_y    <= cut_fn(m_a, m_b);
            end
            m_cnt <= m_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (cut_start && prev_start) b2b_cnt <= b2b_cnt + 1;
        if (cut_start && cut_busy)   busy_start_cnt <= busy_start_cnt + 1;
        prev_start <= cut_start;
    end

    // Reference signature as polynomial long division of (sig*x^16 + y*x^8) by x^8+x^2+x+1.
    function automatic logic [7:0] model_sig();
        logic [15:0] lf;
        logic [7:0]  s;
        logic [23:0] v;
        logic [15:0] y;
        lf = 16'h0001;
        s  = 8'h00;
        for (int p = 0; p < 255; p++) begin
            y = cut_fn(lf[15:8], lf[7:0]);
            v = {s, 16'h0000} ^ {y, 8'h00};
            for (int i = 23; i >= 8; i--)
                if (v[i]) v = v ^ (24'h107 << (i - 8));
            s  = v[7:0];
            lf = {lf[14:0], ^(lf & 16'hB400)};
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
            $display("[%0t] ok %s: %0h", $time, tag, obs);
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(input string tag, input logic [15:0] v, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (out === v) break;
            @(negedge clk);
        end
        check(tag, 32'(out), 32'(v));
    endtask

    task automatic wait_done(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (done === 1'b1) break;
            @(negedge clk);
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_busy(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (cut_busy === 1'b1) break;
            @(negedge clk);
        end
        check(tag, 32'(cut_busy), 32'd1);
    endtask

    task automatic pulse_test();
        @(negedge clk) test = 1'b1;
        @(negedge clk) test = 1'b0;
    endtask

    task automatic check_session(input string tag, input logic [7:0] cnt);
        wait_done({tag, "_done"}, 5000);
        check({tag, "_out"}, 32'(out), 32'({cnt, exp_sig}));
`ifdef BIST_GOLDEN_CMP_EN
        check({tag, "_fail"}, 32'(fail), 32'(exp_sig != 8'h00));
`endif
    endtask

    initial begin
        exp_sig = model_sig();
        $display("reference signature %02h", exp_sig);

        repeat (10) @(negedge clk);
        check("rst_out", 32'(out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_start", 32'(cut_start), 32'd0);
        check("rst_cut_ab", 32'({cut_a, cut_b}), 32'd0);
`ifdef BIST_GOLDEN_CMP_EN
        check("rst_fail", 32'(fail), 32'd0);
`endif
        rst = 1'b1;

        wait_out("norm_2_3", 16'd9, 12);
        a = 8'h8e;
        b = 8'hc2;
        wait_out("norm_8e_c2", 16'd45253, 20);

        pulse_test();
        check_session("sess1", 8'd1);
        repeat (5) @(negedge clk);
        check("sess1_hold_out", 32'(out), 32'({8'd1, exp_sig}));
        check("sess1_hold_done", 32'(done), 32'd1);

        // A held-high test is a single toggle.
        @(negedge clk) test = 1'b1;
        repeat (5) @(negedge clk);
        test = 1'b0;
        wait_out("back_norm1", 16'd45253, 40);
        repeat (40) @(negedge clk);
        check("norm_stable_out", 32'(out), 32'd45253);
        check("norm_stable_done", 32'(done), 32'd0);

        pulse_test();
        check_session("sess2", 8'd2);
        pulse_test();
        wait_out("back_norm2", 16'd45253, 40);

        // Toggle while a normal-mode op is in flight.
        wait_busy("nwait_busy", 20);
        pulse_test();
        check_session("sess3", 8'd3);
        pulse_test();
        wait_out("back_norm3", 16'd45253, 40);

        // Toggle while a test-mode op is in flight aborts the session.
        pulse_test();
        repeat (100) @(negedge clk);
        check("sess4_cnt", 32'(out[15:8]), 32'd4);
        wait_busy("twait_busy", 20);
        pulse_test();
        wait_out("abort_norm", 16'd45253, 40);
        check("abort_done", 32'(done), 32'd0);
        repeat (40) @(negedge clk);
        check("abort_stable", 32'(out), 32'd45253);

        // Asynchronous reset in the middle of a session.
        pulse_test();
        repeat (200) @(negedge clk);
        check("sess5_cnt", 32'(out[15:8]), 32'd5);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_out", 32'(out), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_start", 32'(cut_start), 32'd0);
        check("arst_cut_ab", 32'({cut_a, cut_b}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_out("post_rst_norm", 16'd45253, 30);
        pulse_test();
        check_session("sess_after_rst", 8'd1);

        check("no_b2b_start", 32'(b2b_cnt), 32'd0);
        check("no_start_while_busy", 32'(busy_start_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
